// File: rtl/tile_access_sequencer_if.sv
// Request/response and ring-controller signal bundle for tile_access_sequencer.
// master = game logic plus controller side; slave = the sequencer itself.
interface tile_access_sequencer_if #(
  parameter int unsigned NUM_TILES  = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned STEP_WIDTH = $clog2(NUM_TILES + 1);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [STEP_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic                  src_start;
  logic                  src_write;
  logic [STEP_WIDTH-1:0] src_num_steps;
  logic [DATA_WIDTH-1:0] src_value;
  logic [DATA_WIDTH-1:0] src_buffer;
  logic                  src_last_step;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  src_start, src_write, src_num_steps, src_value,
    output src_buffer, src_last_step
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output src_start, src_write, src_num_steps, src_value,
    input  src_buffer, src_last_step
  );
endinterface

// File: rtl/tile_access_sequencer.sv
// Random-access front end for the ring-buffer shift-register tile memory controller.
// Optional TILE_SEQ_SHIFT_CNT_EN adds a saturating 16-bit shift_count output.
module tile_access_sequencer #(
  parameter int unsigned NUM_TILES  = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WD_SLACK   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tile_access_sequencer_if.slave bus
`ifdef TILE_SEQ_SHIFT_CNT_EN
  ,
  output logic [15:0]            shift_count
`endif
);

  localparam int unsigned STEP_WIDTH = $clog2(NUM_TILES + 1);
  localparam int unsigned SUM_WIDTH  = STEP_WIDTH + 1;
  localparam int unsigned RING       = NUM_TILES + 1;
  localparam int unsigned WD_WIDTH   = $clog2(NUM_TILES * DATA_WIDTH + WD_SLACK + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SETTLE, WRITE0, DONE} state_t;

  state_t                state;
  logic [STEP_WIDTH-1:0] pos;
  logic [STEP_WIDTH-1:0] addr_r;
  logic [WD_WIDTH-1:0]   wd;

  logic [SUM_WIDTH-1:0]  sum_c;
  logic [STEP_WIDTH-1:0] steps_c;
  logic                  bad_addr_c;

  // Forward distance from the buffered slot to the requested slot, modulo RING.
  always_comb begin
    sum_c      = SUM_WIDTH'(bus.req_addr) + SUM_WIDTH'(RING) - SUM_WIDTH'(pos);
    steps_c    = (sum_c >= SUM_WIDTH'(RING)) ? STEP_WIDTH'(sum_c - SUM_WIDTH'(RING))
                                             : STEP_WIDTH'(sum_c);
    bad_addr_c = (bus.req_addr >= STEP_WIDTH'(NUM_TILES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      pos               <= STEP_WIDTH'(NUM_TILES);
      addr_r            <= '0;
      wd                <= '0;
      bus.req_ready     <= 1'b1;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_err      <= 1'b0;
      bus.src_start     <= 1'b0;
      bus.src_write     <= 1'b0;
      bus.src_num_steps <= '0;
      bus.src_value     <= '0;
    end else begin
      bus.src_start  <= 1'b0;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_r        <= bus.req_addr;
            bus.req_ready <= 1'b0;
            if (bad_addr_c) begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (steps_c == '0 && !bus.req_write) begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= bus.src_buffer;
            end else if (steps_c == '0) begin
              state         <= WRITE0;
              bus.src_write <= 1'b1;
              bus.src_value <= bus.req_wdata;
            end else begin
              state             <= LAUNCH;
              bus.src_start     <= 1'b1;
              bus.src_num_steps <= steps_c;
              bus.src_write     <= bus.req_write;
              bus.src_value     <= bus.req_wdata;
            end
          end
        end
        WRITE0: begin
          state          <= DONE;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= bus.src_value;
          bus.src_write  <= 1'b0;
          bus.src_value  <= '0;
        end
        LAUNCH: begin
          state <= WAIT;
          wd    <= WD_WIDTH'(bus.src_num_steps) * WD_WIDTH'(DATA_WIDTH) + WD_WIDTH'(WD_SLACK);
        end
        WAIT: begin
          // Expiry fires on the cycle the counter would reach zero.
          if (bus.src_last_step) begin
            state <= SETTLE;
          end else if (wd <= WD_WIDTH'(1)) begin
            state             <= DONE;
            wd                <= '0;
            bus.resp_valid    <= 1'b1;
            bus.resp_err      <= 1'b1;
            bus.resp_rdata    <= '0;
            bus.src_write     <= 1'b0;
            bus.src_value     <= '0;
            bus.src_num_steps <= '0;
          end else begin
            wd <= wd - WD_WIDTH'(1);
          end
        end
        SETTLE: begin
          state             <= DONE;
          pos               <= addr_r;
          bus.resp_valid    <= 1'b1;
          bus.resp_err      <= 1'b0;
          bus.resp_rdata    <= bus.src_write ? bus.src_value : bus.src_buffer;
          bus.src_write     <= 1'b0;
          bus.src_value     <= '0;
          bus.src_num_steps <= '0;
        end
        DONE: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef TILE_SEQ_SHIFT_CNT_EN
  logic [16:0] shift_sum_c;

  assign shift_sum_c = 17'(shift_count) + 17'(bus.src_num_steps) * 17'(DATA_WIDTH);

  // Accumulates completed shift cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_count <= '0;
    end else if (state == WAIT && bus.src_last_step) begin
      shift_count <= shift_sum_c[16] ? 16'hFFFF : shift_sum_c[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_tile_access_sequencer.sv
// Directed bench for tile_access_sequencer with a behavioural ring-controller model.
module tb_tile_access_sequencer;
  localparam int unsigned NT   = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned RING = NT + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_access_sequencer_if #(.NUM_TILES(NT), .DATA_WIDTH(DW)) bus ();

`ifdef TILE_SEQ_SHIFT_CNT_EN
  logic [15:0] shift_count;
`endif

  tile_access_sequencer #(.NUM_TILES(NT), .DATA_WIDTH(DW), .WD_SLACK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef TILE_SEQ_SHIFT_CNT_EN
    ,
    .shift_count (shift_count)
`endif
  );

  // Ring controller model: one value per slot, buffer shows the current slot.
  logic [7:0] mem [0:16];
  logic [4:0] ctrl_pos;
  assign bus.src_buffer = mem[ctrl_pos];

  int passes = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one request and act as the controller until resp_valid (latency = cycles after accept).
  task automatic run_req(input logic wr, input logic [4:0] addr, input logic [7:0] wdata,
                         input bit hang, output int lat, output int starts,
                         output logic [4:0] nsteps, output logic [7:0] rdata, output logic err);
    int t_last;
    lat = 0; starts = 0; nsteps = '0; rdata = '0; err = 1'b0; t_last = -1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) bus.req_valid = 1'b0;
      bus.src_last_step = 1'b0;
      if (bus.resp_valid) begin
        lat = k + 1; rdata = bus.resp_rdata; err = bus.resp_err;
        break;
      end
      if (bus.src_start) begin
        starts++;
        nsteps = bus.src_num_steps;
        if (!hang) t_last = k + int'(nsteps) * DW;
      end else if (bus.src_write && starts == 0) begin
        mem[ctrl_pos] = bus.src_value;
      end
      if (k == t_last) begin
        bus.src_last_step = 1'b1;
        ctrl_pos = 5'((int'(ctrl_pos) + int'(nsteps)) % RING);
        if (bus.src_write) mem[ctrl_pos] = bus.src_value;
      end
    end
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("resp_pulse_one_cycle", 32'(bus.resp_valid), 32'd0);
    check("ready_after_done", 32'(bus.req_ready), 32'd1);
  endtask

  int lat, starts, quiet;
  logic [4:0] ns;
  logic [7:0] rd;
  logic er;

  initial begin
    for (int i = 0; i < 17; i++) mem[i] = 8'h00;
    mem[3] = 8'h5C;
    ctrl_pos = 5'd16;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.src_last_step = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_src_start", 32'(bus.src_start), 32'd0);
    check("rst_src_steps", 32'(bus.src_num_steps), 32'd0);
    check("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
    rst_n = 1'b1;

    // pos 16 -> addr 0: one step, 3 + 8 cycles
    run_req(1'b0, 5'd0, 8'h00, 1'b0, lat, starts, ns, rd, er);
    check("rd0_steps", 32'(ns), 32'd1);
    check("rd0_starts", 32'(starts), 32'd1);
    check("rd0_lat", 32'(lat), 32'd11);
    check("rd0_data", 32'(rd), 32'h00);
    check("rd0_err", 32'(er), 32'd0);

    // pos 0 -> write addr 5: five steps, 3 + 40 cycles
    run_req(1'b1, 5'd5, 8'h2A, 1'b0, lat, starts, ns, rd, er);
    check("wr5_steps", 32'(ns), 32'd5);
    check("wr5_lat", 32'(lat), 32'd43);
    check("wr5_data", 32'(rd), 32'h2A);

    run_req(1'b0, 5'd5, 8'h00, 1'b0, lat, starts, ns, rd, er);
    check("rd5_starts", 32'(starts), 32'd0);
    check("rd5_lat", 32'(lat), 32'd1);
    check("rd5_data", 32'(rd), 32'h2A);

    // In-place write then read back through the controller buffer
    run_req(1'b1, 5'd5, 8'h77, 1'b0, lat, starts, ns, rd, er);
    check("wr5b_starts", 32'(starts), 32'd0);
    check("wr5b_lat", 32'(lat), 32'd2);
    check("wr5b_data", 32'(rd), 32'h77);
    run_req(1'b0, 5'd5, 8'h00, 1'b0, lat, starts, ns, rd, er);
    check("rd5b_data", 32'(rd), 32'h77);

    // pos 5 -> addr 3 wraps: 15 steps, 3 + 120 cycles
    run_req(1'b0, 5'd3, 8'h00, 1'b0, lat, starts, ns, rd, er);
    check("rd3_steps", 32'(ns), 32'd15);
    check("rd3_lat", 32'(lat), 32'd123);
    check("rd3_data", 32'(rd), 32'h5C);

    run_req(1'b0, 5'd16, 8'h00, 1'b0, lat, starts, ns, rd, er);
    check("bad16_err", 32'(er), 32'd1);
    check("bad16_lat", 32'(lat), 32'd1);
    check("bad16_starts", 32'(starts), 32'd0);
    check("bad16_data", 32'(rd), 32'h00);
    run_req(1'b1, 5'd31, 8'hFF, 1'b0, lat, starts, ns, rd, er);
    check("bad31_err", 32'(er), 32'd1);
    check("bad31_lat", 32'(lat), 32'd1);

    // pos must still be 3
    run_req(1'b0, 5'd3, 8'h00, 1'b0, lat, starts, ns, rd, er);
    check("pos_kept_lat", 32'(lat), 32'd1);
    check("pos_kept_data", 32'(rd), 32'h5C);

    // Controller never finishes: watchdog of 2*8+4 WAIT cycles
    run_req(1'b0, 5'd5, 8'h00, 1'b1, lat, starts, ns, rd, er);
    check("wd_steps", 32'(ns), 32'd2);
    check("wd_err", 32'(er), 32'd1);
    check("wd_lat", 32'(lat), 32'd22);
    run_req(1'b0, 5'd3, 8'h00, 1'b0, lat, starts, ns, rd, er);
    check("wd_pos_kept_lat", 32'(lat), 32'd1);
    check("wd_pos_kept_err", 32'(er), 32'd0);

    // Reset while waiting on the controller
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 5'd7; bus.req_wdata = 8'h99;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("busy_start", 32'(bus.src_start), 32'd1);
    repeat (3) @(negedge clk);
    check("busy_ready", 32'(bus.req_ready), 32'd0);
    check("busy_write", 32'(bus.src_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_write", 32'(bus.src_write), 32'd0);
    check("mid_rst_steps", 32'(bus.src_num_steps), 32'd0);
    check("mid_rst_value", 32'(bus.src_value), 32'd0);
    ctrl_pos = 5'd16;
    quiet = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.resp_valid) quiet++;
    end
    check("mid_rst_no_resp", 32'(quiet), 32'd0);
    run_req(1'b0, 5'd0, 8'h00, 1'b0, lat, starts, ns, rd, er);
    check("post_rst_steps", 32'(ns), 32'd1);
    check("post_rst_lat", 32'(lat), 32'd11);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
